// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcodes, result width and FSM state type for alu_arbiter.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int RES_W = 4;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational one-hot selector; search starts just after ptr_i.
// Revision : 1.0
// ============================================================================
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  logic w_found;
  int   w_start;

  // Walk offsets from the slot after the last grant; first live request wins.
  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    w_start = (int'(ptr_i) + 1) % NREQ;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req_i[i] && (i == ((w_start + k) % NREQ))) begin
          gnt_o[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Arbitrates NREQ requesters onto one 2-bit ALU with a held response.
//            Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_a,
  input  logic [2*NREQ-1:0]     req_b,
  input  logic [2*NREQ-1:0]     req_op,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [RES_W-1:0]      rsp_r
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   w_sel_gnt;
  logic [ID_W-1:0]   w_sel_idx;
  logic [ID_W-1:0]   w_ptr;
  logic [1:0]        w_sel_a, w_sel_b, w_sel_op;
  logic              w_grant_fire;
  logic [RES_W-1:0]  w_result;

  logic [1:0]        a_q, b_q, op_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [RES_W-1:0]  rsp_r_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // A pointer pinned at NREQ-1 makes the search always start at index 0.
  assign w_ptr = ID_W'(NREQ - 1);
`else
  logic [ID_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ID_W'(NREQ - 1);
    end else if (w_grant_fire) begin
      ptr_q <= w_sel_idx;
    end
  end

  assign w_ptr = ptr_q;
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (w_ptr),
    .gnt_o (w_sel_gnt)
  );

  always_comb begin
    w_sel_idx = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_op  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel_gnt[i]) begin
        w_sel_idx = ID_W'(i);
        w_sel_a   = req_a[2*i +: 2];
        w_sel_b   = req_b[2*i +: 2];
        w_sel_op  = req_op[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is only visible in IDLE, so nothing is granted while a response is held.
  always_comb begin
    w_grant_fire = (state_q == IDLE) && !rst && (|req);
    gnt          = w_grant_fire ? w_sel_gnt : '0;
    rsp_valid    = rsp_valid_q;
    rsp_id       = rsp_id_q;
    rsp_r        = rsp_r_q;
  end

  always_comb begin
    case (op_q)
      OP_ADD:  w_result = {2'b00, a_q} + {2'b00, b_q};
      OP_SUB:  w_result = {2'b00, a_q} - {2'b00, b_q};
      OP_AND:  w_result = {2'b00, a_q & b_q};
      OP_OR:   w_result = {2'b00, a_q | b_q};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_r_q     <= '0;
    end else begin
      if (w_grant_fire) begin
        a_q  <= w_sel_a;
        b_q  <= w_sel_b;
        op_q <= w_sel_op;
        id_q <= w_sel_idx;
      end
      if (state_q == EXEC) begin
        rsp_r_q     <= w_result;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if ((state_q == RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed scoreboard bench for alu_arbiter (honours ALU_ARB_FIXED_PRIO_EN).
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_a, req_b, req_op;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic [3:0]        rsp_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         exp_gnt_q[$];
  logic [6:0] exp_rsp_q[$];

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops expected grants and responses as the DUT presents them.
  initial begin
    int         grant_cyc;
    bit         have_grant;
    bit         valid_prev;
    int         eg;
    logic [6:0] er;
    grant_cyc  = 0;
    have_grant = 1'b0;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_grant = 1'b0;
        valid_prev = 1'b0;
      end else begin
        if (gnt != '0) begin
          check("gnt_while_rsp_valid", int'(rsp_valid), 0);
          if (have_grant) check("grant_spacing_ge3", int'((cyc - grant_cyc) >= 3), 1);
          if (exp_gnt_q.size() == 0) begin
            check("gnt_unexpected", int'(gnt), 0);
          end else begin
            eg = exp_gnt_q.pop_front();
            check("gnt_onehot", int'(gnt), 1 << eg);
          end
          grant_cyc  = cyc;
          have_grant = 1'b1;
        end
        if (rsp_valid && !valid_prev) check("grant_to_valid_latency", cyc - grant_cyc, 2);
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp_q.size() == 0) begin
            check("rsp_unexpected", int'({rsp_id, rsp_r}), -1);
          end else begin
            er = exp_rsp_q.pop_front();
            check("rsp_id", int'(rsp_id), int'(er[6:4]));
            check("rsp_r", int'(rsp_r), int'(er[3:0]));
          end
        end
        valid_prev = rsp_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1);
  end

  task automatic set_lane(input int idx, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] op);
    req_a[2*idx +: 2]  = a;
    req_b[2*idx +: 2]  = b;
    req_op[2*idx +: 2] = op;
  endtask

  task automatic wait_grant(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) check(name, 0, 1);
  endtask

  task automatic wait_rsp(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) seen = 1'b1;
    end
    if (!seen) check(name, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int idx, input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] op, input logic [3:0] exp_r);
    set_lane(idx, a, b, op);
    exp_gnt_q.push_back(idx);
    exp_rsp_q.push_back({3'(idx), exp_r});
    req[idx] = 1'b1;
    wait_grant("txn_grant_timeout");
    @(posedge clk);
    #1;
    req[idx] = 1'b0;
    wait_rsp("txn_rsp_timeout");
  endtask

  initial begin
    int order[5];
    int pre_rst_idx;
`ifdef ALU_ARB_FIXED_PRIO_EN
    order       = '{0, 0, 0, 0, 0};
    pre_rst_idx = 0;
`else
    order       = '{0, 1, 2, 3, 0};
    pre_rst_idx = 2;
`endif
    rst       = 1'b1;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", int'(gnt), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_rsp_r", int'(rsp_r), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, subtract wrap and logic ops.
    txn(0, 2'd3, 2'd1 + 2'd1, OP_ADD, 4'd5);
    txn(0, 2'd0, 2'd1, OP_SUB, 4'hF);
    txn(0, 2'd1, 2'd3, OP_SUB, 4'hE);
    txn(2, 2'd2, 2'd3, OP_AND, 4'd2);
    txn(3, 2'd2, 2'd3, OP_OR,  4'd3);

    // All four requesting continuously; lane i computes i+1.
    for (int i = 0; i < NREQ; i++) set_lane(i, 2'(i), 2'd1, OP_ADD);
    for (int n = 0; n < 5; n++) begin
      exp_gnt_q.push_back(order[n]);
      exp_rsp_q.push_back({3'(order[n]), 4'(order[n] + 1)});
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rr_grant_timeout");
      if (n == 4) begin
        @(posedge clk);
        #1;
        req = '0;
      end
      wait_rsp("rr_rsp_timeout");
    end

    // Backpressure: held response, no grants while it is pending.
    set_lane(0, 2'd1, 2'd1, OP_ADD);
    set_lane(1, 2'd3, 2'd3, OP_AND);
    set_lane(2, 2'd1, 2'd2, OP_OR);
    exp_gnt_q.push_back(0);
    exp_rsp_q.push_back({3'd0, 4'd2});
    exp_gnt_q.push_back(1);
    exp_rsp_q.push_back({3'd1, 4'd3});
    rsp_ready = 1'b0;
    req       = 4'b0001;
    wait_grant("bp_first_grant_timeout");
    @(posedge clk);
    #1;
    req = '0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    @(posedge clk);
    #1;
    req = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", int'(rsp_valid), 1);
      check("bp_rsp_r", int'(rsp_r), 2);
      check("bp_rsp_id", int'(rsp_id), 0);
      check("bp_gnt", int'(gnt), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_grant("bp_second_grant_timeout");
    @(posedge clk);
    #1;
    req = '0;
    wait_rsp("bp_rsp_timeout");

    // Reset while the operation is in EXEC discards it.
    set_lane(0, 2'd2, 2'd1, OP_SUB);
    set_lane(1, 2'd1, 2'd1, OP_ADD);
    set_lane(2, 2'd3, 2'd3, OP_ADD);
    set_lane(3, 2'd0, 2'd0, OP_OR);
    exp_gnt_q.push_back(pre_rst_idx);
    req = 4'b1111;
    wait_grant("pre_reset_grant_timeout");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_rsp_valid", int'(rsp_valid), 0);
    check("mid_reset_rsp_r", int'(rsp_r), 0);
    check("mid_reset_gnt", int'(gnt), 0);
    @(posedge clk);
    #1;
    exp_gnt_q.push_back(0);
    exp_rsp_q.push_back({3'd0, 4'd1});
    rst = 1'b0;
    wait_grant("post_reset_grant_timeout");
    @(posedge clk);
    #1;
    req = '0;
    wait_rsp("post_reset_rsp_timeout");

    repeat (3) @(posedge clk);
    check("exp_gnt_drained", exp_gnt_q.size(), 0);
    check("exp_rsp_drained", exp_rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: NREQ, default 4, number of requesters (legal 2..8).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; all ports SHALL be as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  request per requester, level, held until granted.
- req_a  input  2*NREQ  2-bit operand A per requester, slice i = [2i+1:2i].
- req_b  input  2*NREQ  2-bit operand B per requester, same slicing.
- req_op  input  2*NREQ  2-bit opcode per requester, same slicing.
- gnt  output  NREQ  one-hot grant, single-cycle pulse.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  3  index of requester owning the result.
- rsp_r  output  4  result.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-004 In IDLE with req != 0, the block SHALL pulse gnt for exactly one cycle to the selected requester, capture that requester's a, b and op, and move to EXEC on the same edge.
REQ-005 In IDLE with req == 0, gnt SHALL be 0 and the state SHALL hold.
REQ-006 Selection SHALL be round-robin: search starts at (last granted index + 1) mod NREQ; after reset the last granted index SHALL be NREQ-1, so index 0 has first priority.
REQ-007 In EXEC, the block SHALL compute the result from the captured operands, register it into rsp_r, set rsp_valid = 1 and rsp_id = granted index, and move to RESP; this takes exactly one cycle.
REQ-008 Opcode results SHALL be 4 bits wide:
- 00: a+b, zero-extended, range 0..6.
- 01: a-b, modulo 16 (e.g. 0-1 = 4'hF).
- 10: a&b, zero-extended.
- 11: a|b, zero-extended.
REQ-009 In RESP, rsp_valid, rsp_id and rsp_r SHALL stay stable until rsp_valid && rsp_ready is sampled high; on that edge rsp_valid SHALL clear and the state SHALL return to IDLE.
REQ-010 Latency from grant to rsp_valid SHALL be 2 cycles; minimum spacing between consecutive grants SHALL be 3 cycles.
REQ-011 Requests asserted during EXEC or RESP SHALL NOT be granted until the next IDLE cycle; no grant SHALL occur while rsp_valid = 1.
REQ-012 The grant decision SHALL ignore a requester whose req drops before selection; req inputs SHALL be sampled only in IDLE.
REQ-013 For NREQ < 8, the unused high bits of rsp_id SHALL be 0.

Reset
REQ-014 When rst = 1 at a clock edge, the block SHALL enter IDLE and set gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_r = 0, and round-robin pointer = NREQ-1.
REQ-015 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-016 After reset deasserts, the first grant SHALL occur no earlier than the first IDLE cycle after deassertion.

Configuration
REQ-017 The block SHALL support the macro ALU_ARB_FIXED_PRIO_EN:
- Defined: selection is fixed priority, lowest index wins, and the round-robin pointer is not implemented.
- Undefined (default): round-robin per REQ-006.
All other behaviour SHALL be identical in both builds.

Structure
REQ-018 A shared package alu_pkg SHALL hold the opcode constants (OP_ADD=00, OP_SUB=01, OP_AND=10, OP_OR=11), the FSM state type (IDLE/EXEC/RESP) and the 4-bit result width constant.
REQ-019 The selection logic SHALL be one sub-module, rr_arbiter, taking the request vector and pointer and returning a one-hot grant; the compute function SHALL stay inline.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single request: req=0001, a=3, b=2, op=00 -> gnt=0001 for one cycle; 2 cycles later rsp_valid=1, rsp_r=5, rsp_id=0.
- Subtract wrap: a=0, b=1, op=01 -> rsp_r=4'hF; a=1, b=3, op=01 -> rsp_r=4'hE.
- Round-robin: req=1111 held -> grants in order 0,1,2,3,0, each 3 cycles apart with rsp_ready=1; with ALU_ARB_FIXED_PRIO_EN defined, the same stimulus -> index 0 granted every time.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_r/rsp_id stable, gnt=0 throughout despite req=0110; with rsp_ready=1 -> IDLE, next grant to index 1.
- Logic ops: a=2, b=3 -> op=10 gives rsp_r=2; op=11 gives rsp_r=3.
- Reset mid-operation: rst=1 in EXEC -> next cycle rsp_valid=0, rsp_r=0, state IDLE; the next grant for req=1111 goes to index 0.
